// File: rtl/zsdram_wr_arbiter.sv
// zsdram_wr_arbiter: round-robin, non-preemptive sharing of the SDRAM 4-pixel write port.
// Optional build macro ZSDRAM_ARB_TIMEOUT_EN adds a done-timeout with a sticky error flag.
`default_nettype none

module zsdram_wr_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 24,
  parameter int PIX_W       = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           iReq,
  input  logic [NUM_REQ*ADDR_W-1:0]    iAddr,
  input  logic [NUM_REQ*4*PIX_W-1:0]   iData,
  output logic [NUM_REQ-1:0]           oDone,
  output logic [NUM_REQ-1:0]           oGrant,
  output logic                         oSDRAM_Wr_Req,
  output logic [ADDR_W-1:0]            oSDRAM_Wr_Addr,
  output logic [PIX_W-1:0]             oSDRAM_Wr_Data1,
  output logic [PIX_W-1:0]             oSDRAM_Wr_Data2,
  output logic [PIX_W-1:0]             oSDRAM_Wr_Data3,
  output logic [PIX_W-1:0]             oSDRAM_Wr_Data4,
  input  logic                         iSDRAM_Wr_Done,
  output logic                         oTimeoutErr
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BURST_W = 4 * PIX_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [BURST_W-1:0] data_arr [NUM_REQ];
  logic [ADDR_W-1:0]  pick_addr;
  logic [BURST_W-1:0] pick_data;
  logic [IDX_W-1:0]   next_ptr;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      addr_arr[k] = iAddr[k*ADDR_W +: ADDR_W];
      data_arr[k] = iData[k*BURST_W +: BURST_W];
    end
  end

  // Scan highest offset first so the lowest offset from ptr overwrites and wins.
  always_comb begin : rr_pick
    int cand;
    cand       = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (iReq[IDX_W'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign pick_addr = addr_arr[pick_idx];
  assign pick_data = data_arr[pick_idx];
  assign next_ptr  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef ZSDRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             timeout_err;
  assign oTimeoutErr = timeout_err;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
  assign oTimeoutErr        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      owner           <= '0;
      oDone           <= '0;
      oGrant          <= '0;
      oSDRAM_Wr_Req   <= 1'b0;
      oSDRAM_Wr_Addr  <= '0;
      oSDRAM_Wr_Data1 <= '0;
      oSDRAM_Wr_Data2 <= '0;
      oSDRAM_Wr_Data3 <= '0;
      oSDRAM_Wr_Data4 <= '0;
`ifdef ZSDRAM_ARB_TIMEOUT_EN
      to_cnt          <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state           <= ST_ISSUE;
            owner           <= pick_idx;
            oGrant          <= NUM_REQ'(1) << pick_idx;
            oSDRAM_Wr_Req   <= 1'b1;
            oSDRAM_Wr_Addr  <= pick_addr;
            oSDRAM_Wr_Data1 <= pick_data[0*PIX_W +: PIX_W];
            oSDRAM_Wr_Data2 <= pick_data[1*PIX_W +: PIX_W];
            oSDRAM_Wr_Data3 <= pick_data[2*PIX_W +: PIX_W];
            oSDRAM_Wr_Data4 <= pick_data[3*PIX_W +: PIX_W];
`ifdef ZSDRAM_ARB_TIMEOUT_EN
            to_cnt          <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          if (iSDRAM_Wr_Done) begin
            oSDRAM_Wr_Req <= 1'b0;
            oDone         <= oGrant;
            ptr           <= next_ptr;
            state         <= ST_RELEASE;
          end
`ifdef ZSDRAM_ARB_TIMEOUT_EN
          // Abandon a write the controller never acknowledges, still handshaking the owner.
          else if (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            oSDRAM_Wr_Req <= 1'b0;
            oDone         <= oGrant;
            ptr           <= next_ptr;
            timeout_err   <= 1'b1;
            state         <= ST_RELEASE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_RELEASE: begin
          oDone  <= '0;
          oGrant <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
